// File: rtl/control_unit.sv
// Microsequencer for the 16-bit accumulator datapath: fetch/decode/execute, start/halt, illegal-opcode trap.
// Optional feature: define CU_SINGLE_STEP_EN to add a step input that gates each instruction at FETCH1.
module control_unit #(
  parameter int                  OPCODE_W   = 8,
  parameter logic [OPCODE_W-1:0] HALT_OP    = 8'hFF,
  parameter bit                  AUTO_START = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
`ifdef CU_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [OPCODE_W-1:0] IROUT,
  input  logic                z,
  output logic [2:0]          ReadEN,
  output logic [2:0]          WriteEN,
  output logic [2:0]          Inc,
  output logic [3:0]          ALUCon,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                instr_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH1 = 3'd1;
  localparam logic [2:0] S_FETCH2 = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [2:0] RD_AC = 3'd0, RD_PC = 3'd2, RD_DR = 3'd3, RD_RAM = 3'd5, RD_R = 3'd6;
  localparam logic [2:0] WR_AR = 3'd1, WR_DR = 3'd2, WR_IR = 3'd3, WR_PC = 3'd4, WR_R = 3'd5,
                         WR_RAM = 3'd7;
  localparam logic [2:0] INC_AC = 3'd1, INC_PC = 3'd4;
  localparam logic [3:0] ALU_LOAD = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3, ALU_CLR = 4'd4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(8'h00);
  localparam logic [OPCODE_W-1:0] OP_LDAC = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OP_STAC = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_MVAC = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OP_MOVR = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] OP_INAC = OPCODE_W'(8'h07);
  localparam logic [OPCODE_W-1:0] OP_CLAC = OPCODE_W'(8'h08);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(8'h09);
  localparam logic [OPCODE_W-1:0] OP_JMPZ = OPCODE_W'(8'h0A);
  localparam logic [OPCODE_W-1:0] OP_JPNZ = OPCODE_W'(8'h0B);

  logic [2:0]          state_reg, state_next;
  logic [2:0]          t_reg, t_next;
  logic [OPCODE_W-1:0] opcode_reg, opcode_next;
  logic                zlat_reg, zlat_next;
  logic                illegal_reg, illegal_next;
  logic                step_ok, last_step, taken;
  logic [2:0]          rd_next, wr_next, inc_next;
  logic [3:0]          alu_next;
  logic                done_next;

`ifdef CU_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // Conditional branches resolve from the flag captured at DECODE, never the live z.
  assign taken = (opcode_reg == OP_JUMP) ||
                 ((opcode_reg == OP_JMPZ) && zlat_reg) ||
                 ((opcode_reg == OP_JPNZ) && !zlat_reg);

  always_comb begin
    state_next   = state_reg;
    t_next       = t_reg;
    opcode_next  = opcode_reg;
    zlat_next    = zlat_reg;
    illegal_next = illegal_reg;
    rd_next      = RD_AC;
    wr_next      = 3'd0;
    inc_next     = 3'd0;
    alu_next     = 4'd0;
    done_next    = 1'b0;
    last_step    = 1'b0;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next   = S_FETCH1;
          illegal_next = 1'b0;
        end
      end
      S_FETCH1: begin
        if (step_ok) begin
          rd_next    = RD_PC;
          wr_next    = WR_AR;
          state_next = S_FETCH2;
        end
      end
      S_FETCH2: begin
        rd_next    = RD_RAM;
        wr_next    = WR_IR;
        inc_next   = INC_PC;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        opcode_next = IROUT;
        zlat_next   = z;
        t_next      = 3'd0;
        if (IROUT == OP_NOP) begin
          done_next  = 1'b1;
          state_next = S_FETCH1;
        end else if (IROUT == HALT_OP) begin
          state_next = S_HALTED;
        end else if (IROUT <= OP_JPNZ) begin
          state_next = S_EXEC;
        end else begin
          illegal_next = 1'b1;
          state_next   = S_HALTED;
        end
      end
      S_EXEC: begin
        t_next = t_reg + 3'd1;
        case (opcode_reg)
          OP_LDAC, OP_STAC: begin
            case (t_reg)
              3'd0: begin rd_next = RD_PC;  wr_next = WR_AR; end
              3'd1: begin rd_next = RD_RAM; wr_next = WR_DR; inc_next = INC_PC; end
              3'd2: begin rd_next = RD_DR;  wr_next = WR_AR; end
              default: begin
                last_step = 1'b1;
                if (opcode_reg == OP_LDAC) begin
                  rd_next  = RD_RAM;
                  alu_next = ALU_LOAD;
                end else begin
                  rd_next = RD_AC;
                  wr_next = WR_RAM;
                end
              end
            endcase
          end
          OP_MVAC: begin rd_next = RD_AC; wr_next = WR_R; last_step = 1'b1; end
          OP_MOVR: begin rd_next = RD_R; alu_next = ALU_LOAD; last_step = 1'b1; end
          OP_ADD:  begin rd_next = RD_R; alu_next = ALU_ADD;  last_step = 1'b1; end
          OP_SUB:  begin rd_next = RD_R; alu_next = ALU_SUB;  last_step = 1'b1; end
          OP_INAC: begin inc_next = INC_AC; last_step = 1'b1; end
          OP_CLAC: begin alu_next = ALU_CLR; last_step = 1'b1; end
          OP_JUMP, OP_JMPZ, OP_JPNZ: begin
            if (!taken) begin
              inc_next  = INC_PC;
              last_step = 1'b1;
            end else if (t_reg == 3'd0) begin
              rd_next = RD_PC;
              wr_next = WR_AR;
            end else begin
              rd_next   = RD_RAM;
              wr_next   = WR_PC;
              last_step = 1'b1;
            end
          end
          default: last_step = 1'b1;
        endcase
        if (last_step) begin
          done_next  = 1'b1;
          state_next = S_FETCH1;
          t_next     = 3'd0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= AUTO_START ? S_FETCH1 : S_IDLE;
      t_reg       <= 3'd0;
      opcode_reg  <= '0;
      zlat_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t_reg       <= t_next;
      opcode_reg  <= opcode_next;
      zlat_reg    <= zlat_next;
      illegal_reg <= illegal_next;
    end
  end

  assign ReadEN     = rd_next;
  assign WriteEN    = wr_next;
  assign Inc        = inc_next;
  assign ALUCon     = alu_next;
  assign instr_done = done_next;
  assign busy       = (state_reg == S_FETCH1) || (state_reg == S_FETCH2) ||
                      (state_reg == S_DECODE) || (state_reg == S_EXEC);
  assign halted     = (state_reg == S_HALTED);
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a register-level datapath driven by the sequencer, checked against an
// instruction-level model of the accumulator machine (directed cases plus random programs).
module tb_control_unit;
  logic        clk = 1'b0;
  logic        rstn, start;
  logic [7:0]  irout;
  logic        z;
  logic [2:0]  ReadEN, WriteEN, Inc;
  logic [3:0]  ALUCon;
  logic        busy, halted, illegal, instr_done;
`ifdef CU_SINGLE_STEP_EN
  logic        step;
`endif

  logic [15:0] ac, ar, pc, dr, tr, r, ir, bus;
  logic [15:0] mem  [0:255];
  logic [15:0] prog [0:255];
  logic        dp_load;
  logic [15:0] init_ac;

  logic [15:0] m_mem [0:255];
  logic [15:0] m_ac, m_pc, m_r;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk(clk), .rstn(rstn), .start(start),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .IROUT(irout), .z(z),
    .ReadEN(ReadEN), .WriteEN(WriteEN), .Inc(Inc), .ALUCon(ALUCon),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign irout = ir[7:0];
  assign z     = (ac == 16'h0000);

  always_comb begin
    bus = ac;
    case (ReadEN)
      3'd0: bus = ac;
      3'd1: bus = ar;
      3'd2: bus = pc;
      3'd3: bus = dr;
      3'd4: bus = tr;
      3'd5: bus = mem[ar[7:0]];
      3'd6: bus = r;
      default: bus = ir;
    endcase
  end

  // Datapath registers react to whatever the sequencer asserts this cycle.
  always @(posedge clk) begin
    if (dp_load) begin
      mem <= prog;
      ac <= init_ac; pc <= 16'h0; ar <= 16'h0; dr <= 16'h0; tr <= 16'h0; r <= 16'h0; ir <= 16'h0;
    end else begin
      case (WriteEN)
        3'd1: ar <= bus;
        3'd2: dr <= bus;
        3'd3: ir <= bus;
        3'd4: pc <= bus;
        3'd5: r  <= bus;
        3'd6: tr <= bus;
        3'd7: mem[ar[7:0]] <= bus;
        default: ;
      endcase
      case (Inc)
        3'd1: ac <= ac + 16'd1;
        3'd2: ar <= ar + 16'd1;
        3'd3: dr <= dr + 16'd1;
        3'd4: pc <= pc + 16'd1;
        3'd5: r  <= r + 16'd1;
        3'd6: tr <= tr + 16'd1;
        default: ;
      endcase
      case (ALUCon)
        4'd1: ac <= bus;
        4'd2: ac <= ac + bus;
        4'd3: ac <= ac - bus;
        4'd4: ac <= 16'h0;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: executes one instruction, returns its cycle count (F1..last).
  function automatic int model_step();
    logic [7:0]  op;
    logic [15:0] a;
    op = m_mem[m_pc[7:0]][7:0];
    m_pc = m_pc + 16'd1;
    case (op)
      8'h00: return 3;
      8'h01: begin a = m_mem[m_pc[7:0]]; m_pc = m_pc + 16'd1; m_ac = m_mem[a[7:0]]; return 7; end
      8'h02: begin a = m_mem[m_pc[7:0]]; m_pc = m_pc + 16'd1; m_mem[a[7:0]] = m_ac; return 7; end
      8'h03: begin m_r = m_ac; return 4; end
      8'h04: begin m_ac = m_r; return 4; end
      8'h05: begin m_ac = m_ac + m_r; return 4; end
      8'h06: begin m_ac = m_ac - m_r; return 4; end
      8'h07: begin m_ac = m_ac + 16'd1; return 4; end
      8'h08: begin m_ac = 16'h0; return 4; end
      8'h09: begin m_pc = m_mem[m_pc[7:0]]; return 5; end
      8'h0A, 8'h0B: begin
        if ((m_ac == 16'h0) == (op == 8'h0A)) begin
          m_pc = m_mem[m_pc[7:0]];
          return 5;
        end
        m_pc = m_pc + 16'd1;
        return 4;
      end
      default: return -1;
    endcase
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic boot(input logic [15:0] ac0);
    @(negedge clk); rstn = 1'b0; start = 1'b0; dp_load = 1'b1; init_ac = ac0;
    @(negedge clk); dp_load = 1'b0;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 256; i++) m_mem[i] = prog[i];
    m_ac = ac0; m_pc = 16'h0; m_r = 16'h0;
    @(negedge clk); start = 1'b1;
  endtask

  // Follows the running program instruction by instruction until HALTED or max_instr completed.
  task automatic run_prog(input string name, input int max_instr);
    int cyc, n, exp_cyc;
    bit pend;
    logic [7:0] op;
    cyc = 0; n = 0; pend = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (pend) begin
        chk({name, "_ac"}, ac, m_ac);
        chk({name, "_pc"}, pc, m_pc);
        chk({name, "_r"},  r,  m_r);
        pend = 1'b0;
        if (n >= max_instr) return;
      end
      cyc++;
      if (halted) begin
        chk({name, "_halt_op"}, m_mem[m_pc[7:0]], 16'h00FF);
        chk({name, "_halt_cyc"}, cyc, 4);
        return;
      end
      if (instr_done) begin
        op = m_mem[m_pc[7:0]][7:0];
        exp_cyc = model_step();
        $display("%s instr op=%02h cycles=%0d ac=%04h pc=%04h", name, op, cyc, m_ac, m_pc);
        chk({name, "_cycles"}, cyc, exp_cyc);
        cyc = 0; n++; pend = 1'b1;
      end
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic check_mem(input string name);
    int nerr;
    nerr = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) nerr++;
    chk({name, "_mem"}, nerr, 0);
  endtask

  // Random program: legal instructions only, operands point into the data page or at an
  // instruction start, and a closing JUMP 0 keeps the PC inside the code page.
  task automatic gen_random();
    int addr, nst, op;
    int starts [0:127];
    int ops    [0:127];
    for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
    addr = 0; nst = 0;
    while (addr < 'h6E) begin
      op = $urandom_range(0, 11);
      starts[nst] = addr; ops[nst] = op; nst++;
      prog[addr] = 16'(op);
      addr += (op == 1 || op == 2 || op >= 9) ? 2 : 1;
    end
    prog[addr] = 16'h0009; prog[addr + 1] = 16'h0000;
    for (int i = 0; i < nst; i++) begin
      if (ops[i] == 1 || ops[i] == 2) prog[starts[i] + 1] = 16'(8'h80 + $urandom_range(0, 127));
      else if (ops[i] >= 9) prog[starts[i] + 1] = 16'(starts[$urandom_range(0, nst - 1)]);
    end
  endtask

  initial begin
`ifdef CU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    rstn = 1'b0; start = 1'b0; dp_load = 1'b1; init_ac = 16'h0;
    clear_prog();
    repeat (2) @(negedge clk);
    chk("rst_ctl", {ReadEN, WriteEN, Inc, ALUCon}, 0);
    chk("rst_flags", {busy, halted, illegal, instr_done}, 0);

    // CLAC then HALT, cycle by cycle
    clear_prog(); prog[0] = 16'h0008; prog[1] = 16'h00FF;
    boot(16'h0077);
    @(negedge clk); start = 1'b0;
    chk("f1_rd", ReadEN, 2); chk("f1_wr", WriteEN, 1); chk("f1_busy", busy, 1);
    @(negedge clk);
    chk("f2_rd", ReadEN, 5); chk("f2_wr", WriteEN, 3); chk("f2_inc", Inc, 4);
    @(negedge clk);
    chk("dec_ctl", {ReadEN, WriteEN, Inc, ALUCon}, 0); chk("dec_busy", busy, 1);
    @(negedge clk);
    chk("clac_alu", ALUCon, 4); chk("clac_done", instr_done, 1);
    @(negedge clk);
    chk("clac_ac", ac, 0); chk("refetch_rd", ReadEN, 2);
    @(negedge clk);
    @(negedge clk);
    chk("halt_dec_done", instr_done, 0);
    @(negedge clk);
    chk("halt_flag", {halted, busy}, 2'b10);
    chk("halt_ctl", {ReadEN, WriteEN, Inc, ALUCon}, 0);

    // LDAC 0x20, then CLAC;JMPZ and INAC;JMPZ against the model
    clear_prog(); prog[0] = 16'h0001; prog[1] = 16'h0020; prog[2] = 16'h00FF; prog[16'h20] = 16'h1234;
    boot(16'h0000); run_prog("ldac", 10);
    clear_prog(); prog[0] = 16'h0008; prog[1] = 16'h000A; prog[2] = 16'h0040; prog[16'h40] = 16'h00FF;
    boot(16'h0005); run_prog("jmpz_t", 10);
    clear_prog(); prog[0] = 16'h0007; prog[1] = 16'h000A; prog[2] = 16'h0040; prog[3] = 16'h00FF;
    boot(16'h0000); run_prog("jmpz_n", 10);

    // Illegal opcode trap and restart
    clear_prog(); prog[0] = 16'h0055; prog[1] = 16'h00FF;
    boot(16'h0000);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ill_dec_done", instr_done, 0);
    @(negedge clk);
    chk("ill_flags", {halted, illegal, busy}, 3'b110);
    chk("ill_ctl", {ReadEN, WriteEN, Inc, ALUCon}, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ill_clear", illegal, 0); chk("ill_refetch", ReadEN, 2);
    repeat (3) @(negedge clk);
    chk("ill_rehalt", {halted, illegal}, 2'b10);

    // Reset during LDAC t2
    clear_prog(); prog[0] = 16'h0001; prog[1] = 16'h0020; prog[16'h20] = 16'h1234;
    boot(16'h00AB);
    for (int i = 0; i < 6; i++) begin @(negedge clk); start = 1'b0; end
    chk("t2_rd", ReadEN, 3); chk("t2_wr", WriteEN, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_ctl", {ReadEN, WriteEN, Inc, ALUCon}, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    chk("rstmid_ac", ac, 16'h00AB);

    for (int p = 0; p < 3; p++) begin
      gen_random();
      boot(16'($urandom));
      run_prog($sformatf("rand%0d", p), 60);
      rstn = 1'b0;
      @(negedge clk);
      check_mem($sformatf("rand%0d", p));
    end

`ifdef CU_SINGLE_STEP_EN
    clear_prog(); prog[0] = 16'h0007; prog[1] = 16'h0007; prog[2] = 16'h0007;
    step = 1'b0;
    boot(16'h0000);
    @(negedge clk); start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (6) @(negedge clk);
    end
    chk("step_ac", ac, 2);
    chk("step_park", {busy, ReadEN, WriteEN}, 7'b1000000);
    step = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
